idct_vecrot_mult: RTL and testbench

//  Vector-rotation stage of the IDCT-via-IFFT path. Takes the DCT pair D1(k) and D1(N+2-k)
//  and forms F1(k) = (D1(k) - j*D1(N+2-k)) * (cos + j*sin) in one streaming pass.

---
 rtl/idct_vecrot_mult_if.sv | 29 ++
 rtl/idct_vecrot_mult.sv | 204 ++++++++++++++++++++
 tb/tb_idct_vecrot_mult.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/idct_vecrot_mult_if.sv
// Stream bus for idct_vecrot_mult: DCT pair sink side and rotated complex source side.
// master = upstream producer / downstream consumer view, slave = the rotation block's view.
interface idct_vecrot_mult_if #(
  parameter int wDataIn  = 16,
  parameter int wDataOut = 18
);
  logic [11:0]                fftpts_in;
  logic                       sink_valid;
  logic                       sink_sop;
  logic                       sink_eop;
  logic signed [wDataIn-1:0]  sink_a;
  logic signed [wDataIn-1:0]  sink_b;
  logic                       source_valid;
  logic                       source_sop;
  logic                       source_eop;
  logic signed [wDataOut-1:0] source_re;
  logic signed [wDataOut-1:0] source_im;
  logic                       source_error;

  modport master (
    output fftpts_in, sink_valid, sink_sop, sink_eop, sink_a, sink_b,
    input  source_valid, source_sop, source_eop, source_re, source_im, source_error
  );

  modport slave (
    input  fftpts_in, sink_valid, sink_sop, sink_eop, sink_a, sink_b,
    output source_valid, source_sop, source_eop, source_re, source_im, source_error
  );
endinterface

// File: rtl/idct_vecrot_mult.sv
// Vector rotation F1(k) = (D1(k) - j*D1(N+2-k)) * (cos + j*sin), 3-clk latency, Q16 coefficients.
// Define IDCT_VECROT_SAT_EN to clamp the rounded result instead of two's-complement wrap.
module idct_vecrot_mult #(
  parameter int wDataIn  = 16,
  parameter int wCoeff   = 18,
  parameter int wDataOut = 18
) (
  input logic               clk,
  input logic               rst_n_sync,
  idct_vecrot_mult_if.slave bus
);
  localparam int  PW = wDataIn + wCoeff;
  localparam int  SW = PW + 1;
  localparam real PI = 3.14159265358979323846;

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t      state, nxt_state;
  logic [11:0] k_cnt, nxt_k, n_cur, nxt_n, idx;
  logic [10:0] step_cur, nxt_step, addr_acc, nxt_acc, rom_addr;
  logic        emit, emit_eop, err, first, coef_en;

  // Q16 cos over [0, pi/2] with 2048 steps; sin comes from the mirrored index
  logic signed [wCoeff-1:0] cos_tab [0:2048];
  for (genvar i = 0; i <= 2048; i++) begin : g_rom
    localparam real ANG = PI * i / 4096.0;
    assign cos_tab[i] = wCoeff'($rtoi($cos(ANG) * 65536.0 + 0.5));
  end
  localparam logic signed [wCoeff-1:0] C_DC = wCoeff'($rtoi($sqrt(2.0) * 65536.0 + 0.5));

  function automatic logic [10:0] step_of(input logic [11:0] n);
    case (n)
      12'd32:   step_of = 11'd64;
      12'd64:   step_of = 11'd32;
      12'd128:  step_of = 11'd16;
      12'd256:  step_of = 11'd8;
      12'd512:  step_of = 11'd4;
      12'd1024: step_of = 11'd2;
      default:  step_of = 11'd1;
    endcase
  endfunction

  // Beat classification: a sop always restarts counter and ROM address, even inside a frame
  always_comb begin
    nxt_state = state;
    nxt_k     = k_cnt;
    nxt_n     = n_cur;
    nxt_step  = step_cur;
    nxt_acc   = addr_acc;
    emit      = 1'b0;
    emit_eop  = 1'b0;
    err       = 1'b0;
    first     = 1'b0;
    idx       = k_cnt + 12'd1;
    rom_addr  = addr_acc + step_cur;
    if (bus.sink_valid && bus.sink_sop) begin
      err      = (state == IN_FRAME) || bus.sink_eop;
      emit     = !err;
      first    = 1'b1;
      rom_addr = '0;
      if (bus.sink_eop) begin
        nxt_state = IDLE;
      end else begin
        nxt_state = IN_FRAME;
        nxt_k     = 12'd1;
        nxt_n     = bus.fftpts_in;
        nxt_step  = step_of(bus.fftpts_in);
        nxt_acc   = '0;
      end
    end else if (state == IDLE) begin
      err = bus.sink_valid;
    end else if (!bus.sink_valid) begin
      err       = 1'b1;
      nxt_state = IDLE;
    end else if (bus.sink_eop || idx == n_cur) begin
      nxt_state = IDLE;
      if (bus.sink_eop && idx == n_cur) begin
        emit     = 1'b1;
        emit_eop = 1'b1;
      end else begin
        err = 1'b1;
      end
    end else begin
      emit    = 1'b1;
      nxt_k   = idx;
      nxt_acc = rom_addr;
    end
  end

  assign coef_en = bus.sink_valid && (bus.sink_sop || state == IN_FRAME);

  // S1: frame state, input data and coefficient ROM read
  logic                       v1, err1, sop1, eop1;
  logic signed [wDataIn-1:0]  a1, b1;
  logic signed [wCoeff-1:0]   c1, s1;

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state    <= IDLE;
      k_cnt    <= '0;
      n_cur    <= '0;
      step_cur <= '0;
      addr_acc <= '0;
      v1       <= 1'b0;
      err1     <= 1'b0;
      sop1     <= 1'b0;
      eop1     <= 1'b0;
      a1       <= '0;
      b1       <= '0;
      c1       <= '0;
      s1       <= '0;
    end else begin
      state    <= nxt_state;
      k_cnt    <= nxt_k;
      n_cur    <= nxt_n;
      step_cur <= nxt_step;
      addr_acc <= nxt_acc;
      v1       <= emit;
      err1     <= err;
      sop1     <= emit && first;
      eop1     <= emit_eop;
      a1       <= bus.sink_a;
      b1       <= bus.sink_b;
      if (coef_en) begin
        c1 <= first ? C_DC : cos_tab[{1'b0, rom_addr}];
        s1 <= cos_tab[12'd2048 - {1'b0, rom_addr}];
      end
    end
  end

  // S2: four partial products
  logic                 v2, err2, sop2, eop2;
  logic signed [PW-1:0] p_ac, p_bs, p_as, p_bc;

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      v2   <= 1'b0;
      err2 <= 1'b0;
      sop2 <= 1'b0;
      eop2 <= 1'b0;
      p_ac <= '0;
      p_bs <= '0;
      p_as <= '0;
      p_bc <= '0;
    end else begin
      v2   <= v1;
      err2 <= err1;
      sop2 <= sop1;
      eop2 <= eop1;
      p_ac <= PW'(a1) * PW'(c1);
      p_bs <= PW'(b1) * PW'(s1);
      p_as <= PW'(a1) * PW'(s1);
      p_bc <= PW'(b1) * PW'(c1);
    end
  end

  // S3: combine, round half up, reduce
  logic signed [SW-1:0]       re_sum, im_sum, re_rnd, im_rnd;
  logic signed [wDataOut-1:0] re_out, im_out;

  always_comb begin
    re_sum = SW'(p_ac) + SW'(p_bs);
    im_sum = SW'(p_as) - SW'(p_bc);
    re_rnd = (re_sum + SW'(32'sd32768)) >>> 16;
    im_rnd = (im_sum + SW'(32'sd32768)) >>> 16;
  end

`ifdef IDCT_VECROT_SAT_EN
  localparam logic signed [SW-1:0] OUT_MAX = SW'((2 ** (wDataOut - 1)) - 1);
  localparam logic signed [SW-1:0] OUT_MIN = -SW'(2 ** (wDataOut - 1));

  always_comb begin
    if (re_rnd > OUT_MAX)      re_out = OUT_MAX[wDataOut-1:0];
    else if (re_rnd < OUT_MIN) re_out = OUT_MIN[wDataOut-1:0];
    else                       re_out = re_rnd[wDataOut-1:0];
    if (im_rnd > OUT_MAX)      im_out = OUT_MAX[wDataOut-1:0];
    else if (im_rnd < OUT_MIN) im_out = OUT_MIN[wDataOut-1:0];
    else                       im_out = im_rnd[wDataOut-1:0];
  end
`else
  logic unused_hi;
  assign re_out    = re_rnd[wDataOut-1:0];
  assign im_out    = im_rnd[wDataOut-1:0];
  assign unused_hi = ^{re_rnd[SW-1:wDataOut], im_rnd[SW-1:wDataOut]};
`endif

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      bus.source_valid <= 1'b0;
      bus.source_sop   <= 1'b0;
      bus.source_eop   <= 1'b0;
      bus.source_error <= 1'b0;
      bus.source_re    <= '0;
      bus.source_im    <= '0;
    end else begin
      bus.source_valid <= v2;
      bus.source_sop   <= sop2;
      bus.source_eop   <= eop2;
      bus.source_error <= err2;
      bus.source_re    <= re_out;
      bus.source_im    <= im_out;
    end
  end
endmodule

// File: tb/tb_idct_vecrot_mult.sv
// Bench for idct_vecrot_mult: framing-rule model plus Q16 rotation arithmetic, checked every cycle.
module tb_idct_vecrot_mult;
  localparam real PI = 3.14159265358979323846;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  idct_vecrot_mult_if #(.wDataIn(16), .wDataOut(18)) bus ();

  idct_vecrot_mult #(.wDataIn(16), .wCoeff(18), .wDataOut(18)) dut (
    .clk       (clk),
    .rst_n_sync(rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;
  bit run   = 0;

  bit     lit_en = 0;
  longint lit_re = 0;
  longint lit_im = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit supported(input int n);
    return n == 32 || n == 64 || n == 128 || n == 256 || n == 512 || n == 1024 || n == 2048;
  endfunction

  // Rotation angle pi*(k-1)/(2N); k=1 carries the sqrt(2) DC weight; other N use the 2048 table
  function automatic void coef(input int k, input int n, output longint c, output longint s);
    real ang;
    if (k == 1) begin
      c = longint'($floor(65536.0 * $sqrt(2.0) + 0.5));
      s = 0;
      return;
    end
    if (supported(n)) ang = PI * (k - 1) / (2.0 * n);
    else              ang = PI * ((k - 1) % 2048) / 4096.0;
    c = longint'($floor(65536.0 * $cos(ang) + 0.5));
    s = longint'($floor(65536.0 * $sin(ang) + 0.5));
  endfunction

  function automatic longint rnd16(input longint x);
    return longint'($floor(x / 65536.0 + 0.5));
  endfunction

  typedef struct {
    bit     v, sop, eop, err, lit;
    longint re, im, lre, lim;
  } rec_t;

  rec_t   p0, p1, p2;
  bit     m_in;
  int     m_k, m_n;

  always @(posedge clk or negedge rst_n) begin
    rec_t   r;
    longint c, s, a, b;
    if (!rst_n) begin
      p0 = '{default: 0};
      p1 = '{default: 0};
      p2 = '{default: 0};
      m_in = 0;
      m_k = 0;
      m_n = 0;
    end else begin
      r = '{default: 0};
      if (!bus.sink_valid) begin
        if (m_in) begin r.err = 1; m_in = 0; end
      end else if (bus.sink_sop && bus.sink_eop) begin
        r.err = 1;
        m_in = 0;
      end else if (bus.sink_sop) begin
        r.err = m_in;
        r.v = !m_in;
        r.sop = r.v;
        m_in = 1;
        m_k = 1;
        m_n = int'(bus.fftpts_in);
      end else if (!m_in) begin
        r.err = 1;
      end else begin
        m_k++;
        if (m_k == m_n && bus.sink_eop) begin
          r.v = 1; r.eop = 1; m_in = 0;
        end else if (m_k == m_n || bus.sink_eop) begin
          r.err = 1; m_in = 0;
        end else begin
          r.v = 1;
        end
      end
      if (r.v) begin
        coef(m_k, m_n, c, s);
        a = longint'($signed(bus.sink_a));
        b = longint'($signed(bus.sink_b));
        r.re = rnd16(a * c + b * s);
        r.im = rnd16(a * s - b * c);
      end
      r.lit = lit_en && r.v;
      r.lre = lit_re;
      r.lim = lit_im;
      p2 = p1;
      p1 = p0;
      p0 = r;
    end
  end

  always @(negedge clk) begin
    if (rst_n && run) begin
      check("valid", longint'(bus.source_valid), longint'(p2.v));
      check("sop",   longint'(bus.source_sop),   longint'(p2.sop));
      check("eop",   longint'(bus.source_eop),   longint'(p2.eop));
      check("error", longint'(bus.source_error), longint'(p2.err));
      if (p2.v) begin
        check("re", longint'($signed(bus.source_re)), p2.re);
        check("im", longint'($signed(bus.source_im)), p2.im);
      end
      if (p2.lit) begin
        check("lit_re", longint'($signed(bus.source_re)), p2.lre);
        check("lit_im", longint'($signed(bus.source_im)), p2.lim);
      end
    end
  end

  task automatic drive(input bit v, input bit s, input bit e, input int a, input int b, input int n);
    @(negedge clk);
    bus.sink_valid = v;
    bus.sink_sop   = s;
    bus.sink_eop   = e;
    bus.sink_a     = 16'(a);
    bus.sink_b     = 16'(b);
    bus.fftpts_in  = 12'(n);
    lit_en         = 0;
  endtask

  task automatic drive_lit(input bit s, input bit e, input int a, input int b, input int n,
                           input longint lre, input longint lim);
    drive(1, s, e, a, b, n);
    lit_en = 1;
    lit_re = lre;
    lit_im = lim;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) drive(0, 0, 0, 0, 0, 32);
  endtask

  // kind 0 ramp a=k b=n-k, kind 1 random; end_at cuts the frame (drop=1 adds an invalid beat);
  // eop_at places eop (0 = never)
  task automatic frame(input int n, input int kind, input int end_at, input int eop_at, input bit drop);
    for (int k = 1; k <= n; k++) begin
      int a, b;
      if (k == end_at) begin
        if (drop) drive(0, 0, 0, 0, 0, n);
        return;
      end
      if (kind == 0) begin
        a = k;
        b = n - k;
      end else begin
        a = int'($urandom_range(65535)) - 32768;
        b = (k == 1) ? 0 : int'($urandom_range(65535)) - 32768;
      end
      drive(1, k == 1, k == eop_at, a, b, n);
      if (k == eop_at && k < n) return;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, longint'(bus.source_valid), 0);
    check({tag, "_sop"},   longint'(bus.source_sop),   0);
    check({tag, "_eop"},   longint'(bus.source_eop),   0);
    check({tag, "_error"}, longint'(bus.source_error), 0);
    check({tag, "_re"},    longint'($signed(bus.source_re)), 0);
    check({tag, "_im"},    longint'($signed(bus.source_im)), 0);
  endtask

  initial begin
    bus.sink_valid = 0;
    bus.sink_sop   = 0;
    bus.sink_eop   = 0;
    bus.sink_a     = '0;
    bus.sink_b     = '0;
    bus.fftpts_in  = 12'd32;
    #2 rst_n = 0;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1;
    run = 1;
    idle(2);

    // DC weight and first rotation step with hand-computed results
    for (int k = 1; k <= 32; k++) begin
      if (k == 1)      drive_lit(1, 0, 1000, 0, 32, 1414, 0);
      else if (k == 2) drive_lit(0, 0, 1000, 0, 32, 999, 49);
      else             drive(1, 0, k == 32, 0, 0, 32);
    end
    for (int k = 1; k <= 32; k++) begin
      if (k == 2)       drive_lit(0, 0, 0, 1000, 32, 49, -999);
      else if (k == 16) drive_lit(0, 0, 32767, 32767, 32, 46284, -2274);
      else              drive(1, k == 1, k == 32, 0, 0, 32);
    end
    idle(3);

    frame(2048, 0, 0, 2048, 0);
    idle(3);
    frame(64, 1, 20, 64, 1);
    idle(2);
    frame(64, 1, 0, 64, 0);
    frame(128, 1, 0, 128, 0);
    frame(256, 1, 0, 256, 0);
    idle(3);

    frame(32, 1, 10, 32, 0);
    frame(64, 1, 0, 64, 0);
    idle(2);
    frame(32, 1, 0, 5, 0);
    idle(2);
    frame(32, 1, 0, 0, 0);
    idle(2);
    drive(1, 0, 0, 5, 6, 32);
    drive(1, 0, 1, 5, 6, 32);
    drive(1, 1, 1, 7, 8, 32);
    idle(2);
    frame(100, 1, 0, 100, 0);
    frame(512, 1, 0, 512, 0);
    idle(3);

    frame(64, 1, 41, 64, 0);
    @(posedge clk);
    #2 rst_n = 0;
    #1 check_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.sink_valid = 0;
    bus.sink_sop   = 0;
    bus.sink_eop   = 0;
    rst_n = 1;
    idle(4);
    frame(32, 1, 0, 32, 0);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
